// File: rtl/plc_timer_bank.sv
// plc_timer_bank: N_CH independent IEC-style TON/TOF/TP timers sharing one tick prescaler.
// Each channel has MANUAL/AUTO/OFF mode select, a run-time preset, an expiry pulse and elapsed readback.
module plc_timer_bank #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PRESCALE   = 1,
    parameter int unsigned DEF_PRESET = 20,
    parameter int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [N_CH-1:0]     start,
    input  logic [N_CH-1:0]     auto,
    input  logic [N_CH-1:0]     man,
    input  logic [2*N_CH-1:0]   tmode,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_preset,
    input  logic [CH_W-1:0]     rd_ch,
    output logic [CNT_W-1:0]    rd_elapsed,
    output logic [N_CH-1:0]     q,
    output logic [N_CH-1:0]     done
);
    localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]       TM_TOF   = 2'b01;
    localparam logic [1:0]       TM_TP    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q   [N_CH];
    state_t           state_d   [N_CH];
    logic [1:0]       mode_q    [N_CH];
    logic [1:0]       mode_d    [N_CH];
    logic [CNT_W-1:0] elapsed_q [N_CH];
    logic [CNT_W-1:0] elapsed_d [N_CH];
    logic [CNT_W-1:0] preset_q  [N_CH];
    logic [N_CH-1:0]  q_d;
    logic [N_CH-1:0]  done_d;
    logic [N_CH-1:0]  expiry;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] rd_sel_c;

    assign tick = (pre_cnt == PRE_LAST);

    // Free-running tick prescaler, frozen while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (ena) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    // Preset registers; out-of-range channel writes match no entry and are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) preset_q[i] <= CNT_W'(DEF_PRESET);
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_we && (cfg_ch == CH_W'(i))) preset_q[i] <= cfg_preset;
            end
        end
    end

    // Per-channel next state, elapsed count and outputs
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]   = state_q[i];
            mode_d[i]    = mode_q[i];
            elapsed_d[i] = elapsed_q[i];
            q_d[i]       = q[i];
            done_d[i]    = 1'b0;
            expiry[i]    = (state_q[i] == ST_RUN) && (elapsed_q[i] >= preset_q[i]);

            if (man[i]) begin
                state_d[i]   = ST_IDLE;
                elapsed_d[i] = '0;
                q_d[i]       = start[i];
            end else if (!auto[i]) begin
                state_d[i]   = ST_IDLE;
                elapsed_d[i] = '0;
                q_d[i]       = 1'b0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        q_d[i]       = 1'b0;
                        elapsed_d[i] = '0;
                        if (start[i]) begin
                            mode_d[i] = tmode[2*i +: 2];
                            if (tmode[2*i +: 2] == TM_TOF) begin
                                state_d[i] = ST_HOLD;
                                q_d[i]     = 1'b1;
                            end else begin
                                state_d[i] = ST_RUN;
                                q_d[i]     = (tmode[2*i +: 2] == TM_TP);
                            end
                        end
                    end
                    ST_RUN: begin
                        if (mode_q[i] == TM_TOF) begin
                            if (start[i]) begin
                                state_d[i]   = ST_HOLD;
                                elapsed_d[i] = '0;
                            end else if (expiry[i]) begin
                                state_d[i]   = ST_IDLE;
                                elapsed_d[i] = '0;
                                q_d[i]       = 1'b0;
                                done_d[i]    = 1'b1;
                            end else if (tick && (elapsed_q[i] != CNT_MAX)) begin
                                elapsed_d[i] = elapsed_q[i] + CNT_W'(1);
                            end
                        end else if (mode_q[i] == TM_TP) begin
                            if (expiry[i]) begin
                                state_d[i] = ST_HOLD;
                                q_d[i]     = 1'b0;
                                done_d[i]  = 1'b1;
                            end else if (tick && (elapsed_q[i] != CNT_MAX)) begin
                                elapsed_d[i] = elapsed_q[i] + CNT_W'(1);
                            end
                        end else begin
                            if (!start[i]) begin
                                state_d[i]   = ST_IDLE;
                                elapsed_d[i] = '0;
                                q_d[i]       = 1'b0;
                            end else if (expiry[i]) begin
                                state_d[i] = ST_HOLD;
                                q_d[i]     = 1'b1;
                                done_d[i]  = 1'b1;
                            end else if (tick && (elapsed_q[i] != CNT_MAX)) begin
                                elapsed_d[i] = elapsed_q[i] + CNT_W'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!start[i]) begin
                            elapsed_d[i] = '0;
                            if (mode_q[i] == TM_TOF) begin
                                state_d[i] = ST_RUN;
                            end else begin
                                state_d[i] = ST_IDLE;
                                q_d[i]     = 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_d[i]   = ST_IDLE;
                        elapsed_d[i] = '0;
                        q_d[i]       = 1'b0;
                    end
                endcase
            end
        end
    end

    // Channel state registers; ena low holds everything and suppresses done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]   <= ST_IDLE;
                mode_q[i]    <= 2'b00;
                elapsed_q[i] <= '0;
            end
            q    <= '0;
            done <= '0;
        end else begin
            done <= ena ? done_d : '0;
            if (ena) begin
                for (int i = 0; i < N_CH; i++) begin
                    state_q[i]   <= state_d[i];
                    mode_q[i]    <= mode_d[i];
                    elapsed_q[i] <= elapsed_d[i];
                end
                q <= q_d;
            end
        end
    end

    // Readback mux; an unmatched channel index reads as zero
    always_comb begin
        rd_sel_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == CH_W'(i)) rd_sel_c = elapsed_q[i];
        end
    end

    // Registered elapsed readback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_elapsed <= '0;
        end else if (ena) begin
            rd_elapsed <= rd_sel_c;
        end
    end

endmodule

// File: tb/tb_plc_timer_bank.sv
// Bench for plc_timer_bank: directed scenarios plus randomized traffic against a cycle model.
module tb_plc_timer_bank;
    localparam int N   = 3;
    localparam int W   = 16;
    localparam int DEF = 20;
    localparam int IDLE = 0, RUN = 1, HOLD = 2;
    localparam int TON = 0, TOF = 1, TP = 2;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic [N-1:0]  start;
    logic [N-1:0]  auto;
    logic [N-1:0]  man;
    logic [2*N-1:0] tmode;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [W-1:0]  cfg_preset;
    logic [1:0]    rd_ch;
    logic [W-1:0]  rd_elapsed, rd_elapsed3;
    logic [N-1:0]  q, q3, done, done3;

    int n_vec = 0;
    int n_err = 0;

    // Model state per instance (0: PRESCALE=1, 1: PRESCALE=3)
    int m_ph  [2][N];
    int m_ty  [2][N];
    int m_el  [2][N];
    int m_pre [2][N];
    bit m_q   [2][N];
    bit m_dn  [2][N];
    int m_rd  [2];
    int m_ecnt[2];

    plc_timer_bank #(.N_CH(N), .CNT_W(W), .PRESCALE(1), .DEF_PRESET(DEF)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .auto(auto), .man(man),
        .tmode(tmode), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_preset(cfg_preset),
        .rd_ch(rd_ch), .rd_elapsed(rd_elapsed), .q(q), .done(done)
    );

    plc_timer_bank #(.N_CH(N), .CNT_W(W), .PRESCALE(3), .DEF_PRESET(DEF)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .auto(auto), .man(man),
        .tmode(tmode), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_preset(cfg_preset),
        .rd_ch(rd_ch), .rd_elapsed(rd_elapsed3), .q(q3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_preset(input int ch, input int val);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_preset = W'(val);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; start = '0; auto = '0; man = '0; tmode = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_preset = '0; rd_ch = '0;
        repeat (2) step();
        n_vec++;
        if (q !== '0 || done !== '0 || rd_elapsed !== '0) begin
            n_err++; $display("FAIL reset_hold q=%b done=%b rd=%0d want 0/0/0", q, done, rd_elapsed);
        end
        rst_n = 1'b1; ena = 1'b1;
        step();
        n_vec++;
        if (q !== '0 || done !== '0 || rd_elapsed !== '0) begin
            n_err++; $display("FAIL reset_release q=%b done=%b rd=%0d want 0/0/0", q, done, rd_elapsed);
        end
    endtask

    task automatic test_ton();
        auto[0] = 1'b1; tmode[1:0] = 2'b00; rd_ch = 2'd0; start[0] = 1'b1;
        for (int j = 0; j <= 20; j++) begin
            step();
            n_vec++;
            if (q[0] !== 1'b0 || done[0] !== 1'b0) begin
                n_err++; $display("FAIL ton_wait k+%0d q=%b done=%b want 0/0", j, q[0], done[0]);
            end
        end
        step();
        n_vec++;
        if (q[0] !== 1'b1 || done[0] !== 1'b1) begin
            n_err++; $display("FAIL ton_expire q=%b done=%b want 1/1", q[0], done[0]);
        end
        n_vec++;
        if (rd_elapsed !== W'(20)) begin
            n_err++; $display("FAIL ton_elapsed got=%0d want=20", rd_elapsed);
        end
        step();
        n_vec++;
        if (q[0] !== 1'b1 || done[0] !== 1'b0) begin
            n_err++; $display("FAIL ton_done_width q=%b done=%b want 1/0", q[0], done[0]);
        end
        start[0] = 1'b0;
        step();
        n_vec++;
        if (q[0] !== 1'b0) begin
            n_err++; $display("FAIL ton_release q=%b want 0", q[0]);
        end
    endtask

    task automatic test_ton_abort_tof();
        start[0] = 1'b1;
        for (int j = 0; j < 13; j++) begin
            if (j == 10) start[0] = 1'b0;
            step();
            n_vec++;
            if (q[0] !== 1'b0 || done[0] !== 1'b0) begin
                n_err++; $display("FAIL ton_abort c%0d q=%b done=%b want 0/0", j, q[0], done[0]);
            end
        end
        n_vec++;
        if (rd_elapsed !== '0) begin
            n_err++; $display("FAIL ton_abort_elapsed got=%0d want=0", rd_elapsed);
        end
        tmode[1:0] = 2'b01;
        write_preset(0, 5);
        start[0] = 1'b1;
        step();
        n_vec++;
        if (q[0] !== 1'b1) begin
            n_err++; $display("FAIL tof_on q=%b want 1", q[0]);
        end
        step(); step();
        start[0] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step();
            n_vec++;
            if (q[0] !== 1'b1 || done[0] !== 1'b0) begin
                n_err++; $display("FAIL tof_hold c%0d q=%b done=%b want 1/0", j, q[0], done[0]);
            end
        end
        step();
        n_vec++;
        if (q[0] !== 1'b0 || done[0] !== 1'b1) begin
            n_err++; $display("FAIL tof_expire q=%b done=%b want 0/1", q[0], done[0]);
        end
        step();
        n_vec++;
        if (done[0] !== 1'b0) begin
            n_err++; $display("FAIL tof_done_width done=%b want 0", done[0]);
        end
    endtask

    task automatic test_tp();
        int ndone = 0;
        tmode[1:0] = 2'b10;
        write_preset(0, 8);
        for (int j = 0; j < 15; j++) begin
            start[0] = (j < 2) || (j >= 4 && j < 12);
            step();
            if (done[0] === 1'b1) ndone++;
            n_vec++;
            if (q[0] !== (j <= 8) || done[0] !== (j == 9)) begin
                n_err++; $display("FAIL tp_pulse k+%0d q=%b done=%b want %b/%b", j, q[0], done[0], j <= 8, j == 9);
            end
        end
        n_vec++;
        if (ndone != 1) begin
            n_err++; $display("FAIL tp_done_count got=%0d want=1", ndone);
        end
    endtask

    task automatic test_mode_priority();
        bit s;
        man[1] = 1'b1; auto[1] = 1'b1; tmode[3:2] = 2'b00; rd_ch = 2'd1;
        for (int j = 0; j < 20; j++) begin
            s = 1'($urandom_range(0, 1));
            start[1] = s;
            step();
            n_vec++;
            if (q[1] !== s || done[1] !== 1'b0 || rd_elapsed !== '0) begin
                n_err++; $display("FAIL man_follow c%0d q=%b done=%b rd=%0d want %b/0/0", j, q[1], done[1], rd_elapsed, s);
            end
        end
        man[1] = 1'b0; auto[1] = 1'b0; start[1] = 1'b1;
        for (int j = 0; j < 100; j++) begin
            step();
            n_vec++;
            if (q[1] !== 1'b0 || done[1] !== 1'b0) begin
                n_err++; $display("FAIL off_mode c%0d q=%b done=%b want 0/0", j, q[1], done[1]);
            end
        end
        start[1] = 1'b0;
    endtask

    task automatic test_preset_rewrite();
        tmode[1:0] = 2'b00; rd_ch = 2'd0;
        write_preset(0, 20);
        start[0] = 1'b1;
        for (int j = 0; j <= 10; j++) step();
        write_preset(0, 3);
        n_vec++;
        if (q[0] !== 1'b0 || done[0] !== 1'b0) begin
            n_err++; $display("FAIL rewrite_same_edge q=%b done=%b want 0/0", q[0], done[0]);
        end
        step();
        n_vec++;
        if (q[0] !== 1'b1 || done[0] !== 1'b1) begin
            n_err++; $display("FAIL rewrite_expire q=%b done=%b want 1/1", q[0], done[0]);
        end
        n_vec++;
        if (rd_elapsed !== W'(11)) begin
            n_err++; $display("FAIL rewrite_elapsed got=%0d want=11", rd_elapsed);
        end
        start[0] = 1'b0;
        step();
        write_preset(3, 1);
        auto[2] = 1'b1; tmode[5:4] = 2'b00; start[2] = 1'b1; rd_ch = 2'd3;
        for (int j = 0; j <= 20; j++) begin
            step();
            n_vec++;
            if (q[2] !== 1'b0 || rd_elapsed !== '0) begin
                n_err++; $display("FAIL oob_write k+%0d q2=%b rd=%0d want 0/0", j, q[2], rd_elapsed);
            end
        end
        step();
        n_vec++;
        if (q[2] !== 1'b1 || done[2] !== 1'b1) begin
            n_err++; $display("FAIL oob_ch2_expire q=%b done=%b want 1/1", q[2], done[2]);
        end
        start[2] = 1'b0; auto[2] = 1'b0;
        step();
    endtask

    task automatic test_ena_freeze();
        rd_ch = 2'd0;
        write_preset(0, 20);
        start[0] = 1'b1;
        for (int j = 0; j < 5; j++) step();
        ena = 1'b0;
        for (int j = 0; j < 7; j++) begin
            step();
            n_vec++;
            if (q[0] !== 1'b0 || done[0] !== 1'b0 || rd_elapsed !== W'(3)) begin
                n_err++; $display("FAIL ena_freeze c%0d q=%b done=%b rd=%0d want 0/0/3", j, q[0], done[0], rd_elapsed);
            end
        end
        ena = 1'b1;
        for (int j = 0; j < 16; j++) begin
            step();
            n_vec++;
            if (q[0] !== 1'b0) begin
                n_err++; $display("FAIL ena_delay c%0d q=%b want 0", j, q[0]);
            end
        end
        step();
        n_vec++;
        if (q[0] !== 1'b1 || done[0] !== 1'b1) begin
            n_err++; $display("FAIL ena_expire q=%b done=%b want 1/1", q[0], done[0]);
        end
        ena = 1'b0;
        step();
        n_vec++;
        if (q[0] !== 1'b1 || done[0] !== 1'b0) begin
            n_err++; $display("FAIL ena_done_gate q=%b done=%b want 1/0", q[0], done[0]);
        end
        ena = 1'b1; start[0] = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        man[1] = 1'b1; start[1] = 1'b1; start[0] = 1'b1; rd_ch = 2'd0;
        repeat (6) step();
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (q !== '0 || done !== '0 || rd_elapsed !== '0) begin
            n_err++; $display("FAIL async_reset q=%b done=%b rd=%0d want 0/0/0", q, done, rd_elapsed);
        end
        step();
        rst_n = 1'b1; man[1] = 1'b0; start = '0;
        step();
        start[0] = 1'b1;
        for (int j = 0; j <= 21; j++) begin
            step();
            n_vec++;
            if (q[0] !== (j == 21) || done[0] !== (j == 21)) begin
                n_err++; $display("FAIL reset_preset k+%0d q=%b done=%b want %b", j, q[0], done[0], j == 21);
            end
        end
        start[0] = 1'b0;
        step();
    endtask

    // Applies one clock of the timer rules to model instance d
    task automatic model_step(input int d, input int ps);
        bit tk, ex, s;
        int ty;
        if (!ena) begin
            for (int i = 0; i < N; i++) m_dn[d][i] = 1'b0;
        end else begin
            tk = (m_ecnt[d] % ps) == ps - 1;
            m_ecnt[d]++;
            m_rd[d] = (int'(rd_ch) < N) ? m_el[d][rd_ch] : 0;
            for (int i = 0; i < N; i++) begin
                s = start[i];
                m_dn[d][i] = 1'b0;
                if (man[i]) begin
                    m_ph[d][i] = IDLE; m_el[d][i] = 0; m_q[d][i] = s;
                end else if (!auto[i]) begin
                    m_ph[d][i] = IDLE; m_el[d][i] = 0; m_q[d][i] = 1'b0;
                end else begin
                    ex = (m_ph[d][i] == RUN) && (m_el[d][i] >= m_pre[d][i]);
                    ty = m_ty[d][i];
                    if (m_ph[d][i] == IDLE) begin
                        ty = (tmode[2*i +: 2] == 2'b01) ? TOF : (tmode[2*i +: 2] == 2'b10) ? TP : TON;
                        m_q[d][i] = 1'b0; m_el[d][i] = 0;
                        if (s) begin
                            m_ty[d][i] = ty;
                            m_ph[d][i] = (ty == TOF) ? HOLD : RUN;
                            m_q[d][i]  = (ty != TON);
                        end
                    end else if (m_ph[d][i] == RUN) begin
                        if (ty == TON && !s) begin
                            m_ph[d][i] = IDLE; m_el[d][i] = 0; m_q[d][i] = 1'b0;
                        end else if (ty == TOF && s) begin
                            m_ph[d][i] = HOLD; m_el[d][i] = 0;
                        end else if (ex) begin
                            m_dn[d][i] = 1'b1;
                            m_q[d][i]  = (ty == TON);
                            m_ph[d][i] = (ty == TOF) ? IDLE : HOLD;
                            if (ty == TOF) m_el[d][i] = 0;
                        end else if (tk && m_el[d][i] < (1 << W) - 1) begin
                            m_el[d][i]++;
                        end
                    end else if (!s) begin
                        m_el[d][i] = 0;
                        m_ph[d][i] = (ty == TOF) ? RUN : IDLE;
                        if (ty != TOF) m_q[d][i] = 1'b0;
                    end
                end
            end
        end
        if (cfg_we && int'(cfg_ch) < N) m_pre[d][cfg_ch] = int'(cfg_preset);
    endtask

    task automatic test_random();
        logic [N-1:0] eq, ed;
        start = '0; man = '0; auto = '1; tmode = '0; cfg_we = 1'b0; ena = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_rd[d] = 0; m_ecnt[d] = 0;
            for (int i = 0; i < N; i++) begin
                m_ph[d][i] = IDLE; m_ty[d][i] = TON; m_el[d][i] = 0;
                m_pre[d][i] = DEF; m_q[d][i] = 1'b0; m_dn[d][i] = 1'b0;
            end
        end
        for (int c = 0; c < 3000; c++) begin
            ena = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) start[i] = ~start[i];
                if ($urandom_range(0, 79) == 0) man[i] = ~man[i];
                if ($urandom_range(0, 79) == 0) auto[i] = ~auto[i];
            end
            if ($urandom_range(0, 31) == 0) tmode = (2*N)'($urandom);
            cfg_we = ($urandom_range(0, 24) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_preset = W'($urandom_range(0, 8));
            rd_ch = 2'($urandom_range(0, 3));
            model_step(0, 1);
            model_step(1, 3);
            step();
            for (int i = 0; i < N; i++) begin eq[i] = m_q[0][i]; ed[i] = m_dn[0][i]; end
            n_vec++;
            if (q !== eq || done !== ed || rd_elapsed !== W'(m_rd[0])) begin
                n_err++; $display("FAIL rand_ps1 c%0d q=%b done=%b rd=%0d want %b/%b/%0d", c, q, done, rd_elapsed, eq, ed, m_rd[0]);
            end
            for (int i = 0; i < N; i++) begin eq[i] = m_q[1][i]; ed[i] = m_dn[1][i]; end
            n_vec++;
            if (q3 !== eq || done3 !== ed || rd_elapsed3 !== W'(m_rd[1])) begin
                n_err++; $display("FAIL rand_ps3 c%0d q=%b done=%b rd=%0d want %b/%b/%0d", c, q3, done3, rd_elapsed3, eq, ed, m_rd[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ton();
        test_ton_abort_tof();
        test_tp();
        test_mode_priority();
        test_preset_rewrite();
        test_ena_freeze();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
